// File: rtl/uart_ctrl.sv
// Two-requester transmit arbiter and paced send-enable driver for the byte UART,
// plus a single-entry receive holding register with a sticky overrun flag.
module uart_ctrl #(
    parameter int CLK_FREQ  = 50000000,
    parameter int UART_BPS  = 115200,
    parameter int FRAME_GAP = 2,
    parameter int PULSE_LEN = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0,
    input  logic [7:0] data0,
    output logic       ack0,
    input  logic       req1,
    input  logic [7:0] data1,
    output logic       ack1,
    output logic       uart_send_en,
    output logic [7:0] uart_din,
    input  logic       uart_done,
    input  logic [7:0] uart_data,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       rx_overrun,
    input  logic       rx_overrun_clr,
    output logic       tx_busy,
    output logic       grant_id
);

    localparam int BPS_CNT      = CLK_FREQ / UART_BPS;
    localparam int FRAME_CYCLES = BPS_CNT * (10 + FRAME_GAP);
    localparam logic [15:0] FRAME_LAST = 16'(FRAME_CYCLES - 1);
    localparam logic [15:0] PULSE_LAST = 16'(PULSE_LEN - 1);

    typedef enum logic [1:0] {IDLE, PULSE, WAIT} state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        send_en_q, send_en_d;
    logic [7:0]  din_q, din_d;
    logic        ack0_q, ack0_d;
    logic        ack1_q, ack1_d;
    logic        grant_id_q, grant_id_d;
    logic        busy_q, busy_d;
    logic        prev_done_q, prev_done_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rx_valid_q, rx_valid_d;
    logic        rx_overrun_q, rx_overrun_d;
    logic        pick1;
    logic        rise;

    // On a tie, requester 1 wins unless it was the most recent grant.
    assign pick1 = req1 & (~req0 | ~grant_id_q);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        send_en_d  = send_en_q;
        din_d      = din_q;
        ack0_d     = 1'b0;
        ack1_d     = 1'b0;
        grant_id_d = grant_id_q;
        case (state_q)
            IDLE: begin
                if (req0 | req1) begin
                    din_d      = pick1 ? data1 : data0;
                    send_en_d  = 1'b1;
                    ack0_d     = ~pick1;
                    ack1_d     = pick1;
                    grant_id_d = pick1;
                    cnt_d      = '0;
                    state_d    = PULSE;
                end
            end
            PULSE: begin
                cnt_d = cnt_q + 16'd1;
                if (cnt_q == PULSE_LAST) begin
                    send_en_d = 1'b0;
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q + 16'd1;
                if (cnt_q == FRAME_LAST) begin
                    state_d = IDLE;
                end
            end
            default: begin
                send_en_d = 1'b0;
                state_d   = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    assign rise = uart_done & ~prev_done_q;

    always_comb begin
        prev_done_d  = uart_done;
        rx_data_d    = rx_data_q;
        rx_valid_d   = rx_valid_q;
        rx_overrun_d = rx_overrun_q & ~rx_overrun_clr;
        if (rise) begin
            if (!rx_valid_q || rx_ready) begin
                rx_data_d  = uart_data;
                rx_valid_d = 1'b1;
            end else begin
                rx_overrun_d = 1'b1;
            end
        end else if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            send_en_q    <= 1'b0;
            din_q        <= '0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            grant_id_q   <= 1'b0;
            busy_q       <= 1'b0;
            prev_done_q  <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            rx_overrun_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            send_en_q    <= send_en_d;
            din_q        <= din_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            grant_id_q   <= grant_id_d;
            busy_q       <= busy_d;
            prev_done_q  <= prev_done_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            rx_overrun_q <= rx_overrun_d;
        end
    end

    assign ack0         = ack0_q;
    assign ack1         = ack1_q;
    assign uart_send_en = send_en_q;
    assign uart_din     = din_q;
    assign grant_id     = grant_id_q;
    assign tx_busy      = busy_q;
    assign rx_data      = rx_data_q;
    assign rx_valid     = rx_valid_q;
    assign rx_overrun   = rx_overrun_q;

endmodule

// File: tb/tb_uart_ctrl.sv
// Randomized bench for uart_ctrl against a timestamp-based transmit model and a
// one-slot receive model; runs with a short frame for speed.
module tb_uart_ctrl;

    localparam int CLK_FREQ  = 1152000;
    localparam int UART_BPS  = 115200;
    localparam int FRAME_GAP = 2;
    localparam int PULSE_LEN = 4;
    localparam int F         = (CLK_FREQ / UART_BPS) * (10 + FRAME_GAP);

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic [7:0] data0 = '0, data1 = '0;
    logic       ack0, ack1, uart_send_en, tx_busy, grant_id;
    logic [7:0] uart_din, rx_data;
    logic       uart_done = 1'b0;
    logic [7:0] uart_data = '0;
    logic       rx_valid, rx_overrun;
    logic       rx_ready = 1'b0, rx_overrun_clr = 1'b0;

    always #5 clk = ~clk;

    uart_ctrl #(
        .CLK_FREQ (CLK_FREQ),
        .UART_BPS (UART_BPS),
        .FRAME_GAP(FRAME_GAP),
        .PULSE_LEN(PULSE_LEN)
    ) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .data0(data0), .ack0(ack0),
        .req1(req1), .data1(data1), .ack1(ack1),
        .uart_send_en(uart_send_en), .uart_din(uart_din),
        .uart_done(uart_done), .uart_data(uart_data),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .rx_overrun(rx_overrun), .rx_overrun_clr(rx_overrun_clr),
        .tx_busy(tx_busy), .grant_id(grant_id)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    bit         dut_log[$];

    int unsigned t = 0;
    bit          granted = 0;
    int unsigned last_grant = 0;
    bit          last_id = 0;
    logic [7:0]  m_din = '0;
    bit          m_ack0 = 0, m_ack1 = 0;
    bit          m_prev = 0, m_valid = 0, m_ovr = 0;
    logic [7:0]  m_rx = '0;

    int push_pct = 0, rx_pct = 0, rdy_pct = 0;
    bit rand_rx = 0;
    int done_left = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        granted = 0; last_id = 0; m_din = '0; m_ack0 = 0; m_ack1 = 0;
        m_prev = 0; m_valid = 0; m_ovr = 0; m_rx = '0;
    endtask

    // Grants are timestamped; every other TX output follows from the age of the last grant.
    task automatic model_step();
        bit id, rise, drop;
        t++;
        m_ack0 = 0; m_ack1 = 0;
        if ((!granted || (t - last_grant) > F) && (req0 || req1)) begin
            id = (req0 && req1) ? !last_id : req1;
            granted = 1; last_grant = t; last_id = id;
            m_din = id ? data1 : data0;
            if (id) m_ack1 = 1; else m_ack0 = 1;
        end
        rise = uart_done && !m_prev;
        m_prev = uart_done;
        drop = 0;
        if (rise) begin
            if (m_valid && !rx_ready) drop = 1;
            else begin m_rx = uart_data; m_valid = 1; end
        end else if (rx_ready) begin
            m_valid = 0;
        end
        if (drop) m_ovr = 1;
        else if (rx_overrun_clr) m_ovr = 0;
    endtask

    task automatic compare_all();
        bit live_send, live_busy;
        live_send = granted && (t - last_grant) < PULSE_LEN;
        live_busy = granted && (t - last_grant) < F;
        check("ack0", ack0, m_ack0);
        check("ack1", ack1, m_ack1);
        check("grant_id", grant_id, last_id);
        check("send_en", uart_send_en, live_send);
        check("uart_din", uart_din, m_din);
        check("tx_busy", tx_busy, live_busy);
        check("rx_valid", rx_valid, m_valid);
        check("rx_data", rx_data, m_rx);
        check("rx_overrun", rx_overrun, m_ovr);
        if (ack0 || ack1) dut_log.push_back(grant_id);
    endtask

    task automatic present();
        req0 = (q0.size() != 0);
        req1 = (q1.size() != 0);
        data0 = req0 ? q0[0] : 8'($urandom);
        data1 = req1 ? q1[0] : 8'($urandom);
    endtask

    task automatic drive();
        if (m_ack0 && q0.size() != 0) void'(q0.pop_front());
        if (m_ack1 && q1.size() != 0) void'(q1.pop_front());
        if ($urandom_range(0, 99) < push_pct) q0.push_back(8'($urandom));
        if ($urandom_range(0, 99) < push_pct) q1.push_back(8'($urandom));
        present();
        if (rand_rx) begin
            if (done_left > 0) done_left--;
            else if (uart_done) uart_done = 1'b0;
            else if ($urandom_range(0, 99) < rx_pct) begin
                uart_done = 1'b1;
                uart_data = 8'($urandom);
                done_left = $urandom_range(0, 2);
            end
            rx_ready = ($urandom_range(0, 99) < rdy_pct);
            rx_overrun_clr = ($urandom_range(0, 9) == 0);
        end
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            compare_all();
            drive();
        end
    endtask

    task automatic rx_event(input logic [7:0] b, input logic rdy, input logic clr);
        uart_done = 1'b1; uart_data = b; rx_ready = rdy; rx_overrun_clr = clr;
        run(1);
        uart_done = 1'b0; rx_ready = 1'b0; rx_overrun_clr = 1'b0;
        run(1);
    endtask

    initial begin
        bit pat[4];
        pat = '{1'b1, 1'b0, 1'b1, 1'b0};

        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        compare_all();

        // single byte from requester 0
        q0.push_back(8'hA5);
        present();
        dut_log.delete();
        run(F + 10);
        check("a5_grants", dut_log.size(), 1);
        if (dut_log.size() > 0) check("a5_id", dut_log[0], 0);

        // both requesters held: alternation starting with requester 1
        q0.push_back(8'h11); q0.push_back(8'h11);
        q1.push_back(8'h22); q1.push_back(8'h22);
        present();
        dut_log.delete();
        run(4 * (F + 1) + 10);
        check("tie_grants", dut_log.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < dut_log.size()) check("tie_order", dut_log[i], pat[i]);

        // receive path: overrun, set-beats-clear, consume-and-replace
        rx_event(8'h3C, 1'b0, 1'b0);
        check("rx_first", rx_data, 8'h3C);
        rx_event(8'hC3, 1'b0, 1'b0);
        check("rx_ovr_set", rx_overrun, 1);
        check("rx_kept", rx_data, 8'h3C);
        rx_event(8'h55, 1'b0, 1'b1);
        check("rx_set_wins", rx_overrun, 1);
        rx_overrun_clr = 1'b1;
        run(1);
        rx_overrun_clr = 1'b0;
        rx_event(8'h7E, 1'b1, 1'b0);
        check("rx_replace", rx_data, 8'h7E);
        check("rx_replace_v", rx_valid, 1);
        check("rx_replace_ovr", rx_overrun, 0);

        // async reset two cycles into a requester-1 pulse
        q1.push_back(8'h9A);
        present();
        for (int i = 0; i < 3 * F; i++) begin
            if (granted && last_id && (t - last_grant) == 2) break;
            run(1);
        end
        check("pulse_reached", granted && last_id && (t - last_grant) == 2, 1);
        reset = 1'b1;
        #1;
        check("rst_send_en", uart_send_en, 0);
        check("rst_busy", tx_busy, 0);
        check("rst_grant_id", grant_id, 0);
        q0.push_back(8'h01);
        q1.push_back(8'h02);
        present();
        uart_done = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        dut_log.delete();
        run(2 * (F + 1) + 5);
        check("post_rst_grants", dut_log.size(), 2);
        if (dut_log.size() > 1) begin
            check("post_rst_first", dut_log[0], 1);
            check("post_rst_second", dut_log[1], 0);
        end

        // free-running random traffic on both paths
        push_pct = 3; rx_pct = 20; rdy_pct = 30; rand_rx = 1;
        run(4000);
        push_pct = 0;
        run(3 * (F + 1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
